// File: rtl/example_and_pkg.sv
// example_and_pkg: shared constants and types for the example_and smoke-test block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
`timescale 1ns/1ps
package example_and_pkg;

    // Default width of the high-cycle counter. Legal widths are 1..32.
    localparam int CNT_W_DEFAULT = 16;

    // Counter word at the default width.
    typedef logic [CNT_W_DEFAULT-1:0] hi_cnt_t;

endpackage

// File: rtl/example_and_satcnt.sv
// example_and_satcnt: saturating up-counter with synchronous clear; sat flags all-ones.
// Latency: cnt updates one cycle after inc/clr; sat follows cnt combinationally.
// Backpressure: none; inc is sampled every cycle and is dropped once saturated.
`timescale 1ns/1ps
module example_and_satcnt
    import example_and_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Next count: clear dominates; otherwise increment unless already at all-ones,
    // so the counter holds at the top instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter state, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign sat = (cnt_q == CNT_MAX);

endmodule

// File: rtl/example_and.sv
// example_and: combinational a&b plus registered copy and saturating high-cycle monitor.
// Latency: c is zero-latency; c_q, hi_cnt one cycle; optional rise/fall (EXAMPLE_AND_EDGE_EN).
// Backpressure: none; every cycle is sampled.
`timescale 1ns/1ps
module example_and
    import example_and_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             clr,
    output logic             c,
    output logic             c_q,
    output logic [CNT_W-1:0] hi_cnt,
    output logic             cnt_sat,
    output logic             rise,
    output logic             fall
);

    // The gate itself: no masking, so X on an input propagates to c.
    assign c = a & b;

    logic c_d;

    // Next value of the registered copy is just the gate output.
    always_comb begin
        c_d = c;
    end

    // Registered copy of the AND result, cleared by reset but not by clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_q <= 1'b0;
        end else begin
            c_q <= c_d;
        end
    end

    // High-cycle counter; counts the same a&b value that c_q captures.
    example_and_satcnt #(
        .CNT_W (CNT_W)
    ) u_satcnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (c),
        .cnt (hi_cnt),
        .sat (cnt_sat)
    );

`ifdef EXAMPLE_AND_EDGE_EN
    // c_prev_q is the previous c_q, giving one-cycle edge pulses from registers only.
    logic c_prev_d;
    logic c_prev_q;

    // Delay line input is the current registered copy.
    always_comb begin
        c_prev_d = c_q;
    end

    // Previous-c_q register; reset keeps both pulses low right after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_prev_q <= 1'b0;
        end else begin
            c_prev_q <= c_prev_d;
        end
    end

    assign rise = c_q & ~c_prev_q;
    assign fall = ~c_q & c_prev_q;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_example_and.sv
`timescale 1ns/1ps
module tb_example_and;

    logic        clk;
    logic        rst;
    logic        a;
    logic        b;
    logic        clr;
    logic        c16, cq16, sat16, rise16, fall16;
    logic [15:0] cnt16;
    logic        c3, cq3, sat3, rise3, fall3;
    logic [2:0]  cnt3;

    int compared = 0;
    int mismatched = 0;

`ifdef EXAMPLE_AND_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    example_and #(.CNT_W(16)) dut16 (
        .clk(clk), .rst(rst), .a(a), .b(b), .clr(clr),
        .c(c16), .c_q(cq16), .hi_cnt(cnt16), .cnt_sat(sat16),
        .rise(rise16), .fall(fall16)
    );

    example_and #(.CNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .a(a), .b(b), .clr(clr),
        .c(c3), .c_q(cq3), .hi_cnt(cnt3), .cnt_sat(sat3),
        .rise(rise3), .fall(fall3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check registered state of both instances.
    task automatic check_regs(input string tag, input logic cq, input int n16, input int n3,
                              input logic r, input logic f);
        check({tag, ".c_q16"}, 32'(cq16), 32'(cq));
        check({tag, ".c_q3"}, 32'(cq3), 32'(cq));
        check({tag, ".cnt16"}, 32'(cnt16), n16);
        check({tag, ".sat16"}, 32'(sat16), 32'(n16 == 65535));
        check({tag, ".cnt3"}, 32'(cnt3), n3);
        check({tag, ".sat3"}, 32'(sat3), 32'(n3 == 7));
        check({tag, ".rise"}, 32'(rise16), 32'(r & EDGE));
        check({tag, ".fall"}, 32'(fall16), 32'(f & EDGE));
        check({tag, ".rise3"}, 32'(rise3), 32'(r & EDGE));
        check({tag, ".fall3"}, 32'(fall3), 32'(f & EDGE));
    endtask

    logic [1:0] tt_in  [4];
    logic       tt_exp [4];
    bit         rand_bad;

    initial begin
        rst = 1'b1; clr = 1'b0; a = 1'b0; b = 1'b0;
        tt_in[0] = 2'b00; tt_exp[0] = 1'b0;
        tt_in[1] = 2'b01; tt_exp[1] = 1'b0;
        tt_in[2] = 2'b10; tt_exp[2] = 1'b0;
        tt_in[3] = 2'b11; tt_exp[3] = 1'b1;

        // Truth table with reset held: c is combinational and valid in reset.
        #2;
        for (int i = 0; i < 4; i++) begin
            a = tt_in[i][1]; b = tt_in[i][0];
            #1;
            check($sformatf("tt%0d.c16", i), 32'(c16), 32'(tt_exp[i]));
            check($sformatf("tt%0d.c3", i), 32'(c3), 32'(tt_exp[i]));
        end

        // Reset state, with a&b=1 and clr=1 both active: reset dominates.
        clr = 1'b1;
        tick();
        tick();
        check_regs("reset", 1'b0, 0, 0, 1'b0, 1'b0);

        // First cycle after reset with c low.
        rst = 1'b0; clr = 1'b0; a = 1'b0; b = 1'b0;
        tick();
        check_regs("post_rst", 1'b0, 0, 0, 1'b0, 1'b0);

        // Register latency: one cycle of a=b=1.
        a = 1'b1; b = 1'b1;
        tick();
        check_regs("lat1", 1'b1, 1, 1, 1'b1, 1'b0);
        a = 1'b0;
        #1;
        check("lat.c_now", 32'(c16), 32'(0));
        check("lat.cq_hold", 32'(cq16), 32'(1));
        tick();
        check_regs("lat2", 1'b0, 1, 1, 1'b0, 1'b1);
        tick();
        check_regs("lat3", 1'b0, 1, 1, 1'b0, 1'b0);

        // Counting: reset, then five cycles of a=b=1.
        rst = 1'b1;
        tick();
        check_regs("cnt_rst", 1'b0, 0, 0, 1'b0, 1'b0);
        rst = 1'b0; a = 1'b1; b = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check_regs($sformatf("cnt%0d", k), 1'b1, k, k, k == 1, 1'b0);
        end

        // Clear while a&b=1: cleared, that cycle not counted, c_q still updates.
        clr = 1'b1;
        tick();
        check_regs("clr1", 1'b1, 0, 0, 1'b0, 1'b0);

        // Resume counting; the 3-bit instance saturates at 7 and holds.
        clr = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check_regs($sformatf("sat%0d", k), 1'b1, k, (k > 7) ? 7 : k, 1'b0, 1'b0);
        end

        // Clear out of saturation.
        clr = 1'b1;
        tick();
        check_regs("clr2", 1'b1, 0, 0, 1'b0, 1'b0);

        // Reset mid-count leaves no residual state.
        clr = 1'b0;
        tick();
        tick();
        check_regs("mid2", 1'b1, 2, 2, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        check_regs("mid_rst", 1'b0, 0, 0, 1'b0, 1'b0);
        rst = 1'b0; a = 1'b0;
        tick();
        check_regs("mid_post", 1'b0, 0, 0, 1'b0, 1'b0);

        // Edge pattern c = 0,1,1,0.
        a = 1'b1;
        tick();
        check_regs("edge1", 1'b1, 1, 1, 1'b1, 1'b0);
        tick();
        check_regs("edge2", 1'b1, 2, 2, 1'b0, 1'b0);
        a = 1'b0;
        tick();
        check_regs("edge3", 1'b0, 2, 2, 1'b0, 1'b1);
        tick();
        check_regs("edge4", 1'b0, 2, 2, 1'b0, 1'b0);

        // Random combinational check, stopping at the first mismatch.
        rand_bad = 1'b0;
        for (int i = 0; i < 1000 && !rand_bad; i++) begin
            a = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            #0.1;
            compared++;
            assert (c16 === (a & b)) else begin
                mismatched++;
                rand_bad = 1'b1;
                $error("FAIL rand_c iter=%0d a=%0b b=%0b observed c=%0b expected a&b=%0b",
                       i, a, b, c16, a & b);
            end
            #0.4;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
